// File: rtl/regbank_write_arbiter_pkg.sv
// Shared constants and types for the register-bank write-back arbiter.
// Requester indices follow the write-back sources: ALU, load, move/immediate.
package regbank_write_arbiter_pkg;

    localparam int REG_ADDR_W  = 4;
    localparam int REG_DATA_W  = 32;
    localparam int NUM_REGS    = 16;
    localparam int NUM_REQ_DEF = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LDR = 1;
    localparam int REQ_MOV = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
        logic                  en;
    } wr_port_t;

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Write-back request bus, issue-stage reservation/hazard signals and the
// registered register-bank write port. master = requesters/issue, slave = arbiter.
interface regbank_write_arbiter_if
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
);
    localparam int NREG = 1 << ADDR_W;

    logic [NUM_REQ-1:0]        Req_Valid;
    logic [NUM_REQ*ADDR_W-1:0] Req_Dest;
    logic [NUM_REQ*DATA_W-1:0] Req_Data;
    logic [NUM_REQ-1:0]        Req_Ready;

    logic                      Reserve_Valid;
    logic [ADDR_W-1:0]         Reserve_Dest;
    logic                      Reserve_Ready;

    logic [ADDR_W-1:0]         Source1_ADDR;
    logic [ADDR_W-1:0]         Source2_ADDR;
    logic                      Stall;

    logic [ADDR_W-1:0]         Destination;
    logic                      Write_En;
    logic [DATA_W-1:0]         LDR_MUX;
    logic [NREG-1:0]           Busy;

    modport master (
        output Req_Valid, Req_Dest, Req_Data, Reserve_Valid, Reserve_Dest,
               Source1_ADDR, Source2_ADDR,
        input  Req_Ready, Reserve_Ready, Stall, Destination, Write_En, LDR_MUX, Busy
    );

    modport slave (
        input  Req_Valid, Req_Dest, Req_Data, Reserve_Valid, Reserve_Dest,
               Source1_ADDR, Source2_ADDR,
        output Req_Ready, Reserve_Ready, Stall, Destination, Write_En, LDR_MUX, Busy
    );

endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Round-robin grant: first set request bit at or after ptr+1, wrapping.
// Purely combinational, one-hot (or zero) grant.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register-bank write-back arbiter: round-robin over requesters, 1-cycle write
// port, optional busy scoreboard / RAW stall (macro REGBANK_ARB_SCOREBOARD_EN).
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    regbank_write_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   g_idx;
    logic [NUM_REQ-1:0] req_m;
    logic [NUM_REQ-1:0] gnt;
    logic               wr_acc;
    logic [ADDR_W-1:0]  sel_dest;
    logic [DATA_W-1:0]  sel_data;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  dest_q;
    logic [DATA_W-1:0]  data_q;

    // Masking requests in reset keeps Req_Ready low while Reset_n is low.
    assign req_m = Reset_n ? bus.Req_Valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req (req_m),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign bus.Req_Ready = gnt;
    assign wr_acc        = |gnt;

    always_comb begin
        g_idx    = '0;
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                g_idx    = PTR_W'(i);
                sel_dest = bus.Req_Dest[i*ADDR_W +: ADDR_W];
                sel_data = bus.Req_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset pointer to the last requester so requester 0 wins first.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ptr     <= PTR_W'(NUM_REQ - 1);
            wr_en_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= wr_acc;
            if (wr_acc) begin
                ptr    <= g_idx;
                dest_q <= sel_dest;
                data_q <= sel_data;
            end
        end
    end

    assign bus.Write_En    = wr_en_q;
    assign bus.Destination = dest_q;
    assign bus.LDR_MUX     = data_q;

`ifdef REGBANK_ARB_SCOREBOARD_EN
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            wr_hit_rsv;
    logic            rsv_ready;
    logic            rsv_acc;

    // A busy register may be re-reserved in the very cycle its pending write
    // retires: the write clears the old entry, the reservation sets the new one.
    assign wr_hit_rsv = wr_acc && (sel_dest == bus.Reserve_Dest);
    assign rsv_ready  = Reset_n && (!busy[bus.Reserve_Dest] || wr_hit_rsv);
    assign rsv_acc    = bus.Reserve_Valid && rsv_ready;

    always_comb begin
        busy_nxt = busy;
        if (wr_acc)  busy_nxt[sel_dest]         = 1'b0;
        if (rsv_acc) busy_nxt[bus.Reserve_Dest] = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) busy <= '0;
        else          busy <= busy_nxt;
    end

    assign bus.Busy          = busy;
    assign bus.Stall         = busy[bus.Source1_ADDR] | busy[bus.Source2_ADDR];
    assign bus.Reserve_Ready = rsv_ready;
`else
    logic unused_sb;
    assign unused_sb = ^{bus.Reserve_Valid, bus.Reserve_Dest,
                         bus.Source1_ADDR, bus.Source2_ADDR};

    assign bus.Busy          = '0;
    assign bus.Stall         = 1'b0;
    assign bus.Reserve_Ready = 1'b1;
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed vector table, scoreboard corner
// sequences and randomized traffic against a behavioural model.
module tb_regbank_write_arbiter;
    import regbank_write_arbiter_pkg::*;

`ifdef REGBANK_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    localparam logic [11:0] D0  = 12'h321;
    localparam logic [95:0] DT0 = {32'h33, 32'h22, 32'h11};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regbank_write_arbiter_if bus ();
    regbank_write_arbiter dut (.Clock(clk), .Reset_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: last granted requester, pending registers,
    // and the write the bank should see this cycle.
    int          m_ptr;
    logic [15:0] m_busy;
    logic        m_en;
    logic [3:0]  m_dest;
    logic [31:0] m_data;

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [11:0] dest;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        wr_port_t    exp_wr;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [11:0] d,
                                input logic [95:0] dt, input logic [2:0] rdy,
                                input logic [3:0] wd, input logic [31:0] wdt, input logic we);
        vec_t x;
        x.rst = r; x.valid = v; x.dest = d; x.data = dt; x.exp_ready = rdy;
        x.exp_wr.dest = wd; x.exp_wr.data = wdt; x.exp_wr.en = we;
        return x;
    endfunction

    function automatic logic [3:0] dest_of(input int g);
        return bus.Req_Dest[g*4 +: 4];
    endfunction

    function automatic logic [31:0] data_of(input int g);
        return bus.Req_Data[g*32 +: 32];
    endfunction

    function automatic int exp_grant();
        int i;
        if (!rst_n) return -1;
        for (int k = 1; k <= 3; k++) begin
            i = (m_ptr + k) % 3;
            if (bus.Req_Valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic exp_rr();
        int g;
        if (!SB) return 1'b1;
        if (!rst_n) return 1'b0;
        g = exp_grant();
        return !m_busy[bus.Reserve_Dest] || (g >= 0 && dest_of(g) == bus.Reserve_Dest);
    endfunction

    task automatic model_update();
        int   g;
        logic rr;
        g  = exp_grant();
        rr = exp_rr();
        if (!rst_n) begin
            m_ptr = 2; m_busy = '0; m_en = 1'b0; m_dest = '0; m_data = '0;
        end else begin
            m_en = (g >= 0);
            if (g >= 0) begin
                m_dest = dest_of(g);
                m_data = data_of(g);
                m_ptr  = g;
                if (SB) m_busy[m_dest] = 1'b0;
            end
            if (SB && bus.Reserve_Valid && rr) m_busy[bus.Reserve_Dest] = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic r, input logic [2:0] v, input logic [11:0] d,
                          input logic [95:0] dt, input logic rv, input logic [3:0] rd,
                          input logic [3:0] s1, input logic [3:0] s2);
        rst_n = r;
        bus.Req_Valid = v; bus.Req_Dest = d; bus.Req_Data = dt;
        bus.Reserve_Valid = rv; bus.Reserve_Dest = rd;
        bus.Source1_ADDR = s1; bus.Source2_ADDR = s2;
    endtask

    task automatic chk_model();
        int g;
        g = exp_grant();
        chk("ready",     32'(bus.Req_Ready),     (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("rsv_ready", 32'(bus.Reserve_Ready), 32'(exp_rr()));
        chk("stall",     32'(bus.Stall),
            32'(m_busy[bus.Source1_ADDR] | m_busy[bus.Source2_ADDR]));
        chk("busy",      32'(bus.Busy),          32'(m_busy));
        chk("write_en",  32'(bus.Write_En),      32'(m_en));
        chk("dest",      32'(bus.Destination),   32'(m_dest));
        chk("ldr_mux",   bus.LDR_MUX,            m_data);
    endtask

    initial begin
        // Round-robin order from reset, single LDR write, pointer wrap, reset mid-traffic.
        tbl[0]  = mk(1'b0, 3'b111, D0, DT0, 3'b000, 4'h0, 32'h0, 1'b0);
        tbl[1]  = mk(1'b1, 3'b111, D0, DT0, 3'b001, 4'h0, 32'h0, 1'b0);
        tbl[2]  = mk(1'b1, 3'b111, D0, DT0, 3'b010, 4'h1, 32'h11, 1'b1);
        tbl[3]  = mk(1'b1, 3'b111, D0, DT0, 3'b100, 4'h2, 32'h22, 1'b1);
        tbl[4]  = mk(1'b1, 3'b111, D0, DT0, 3'b001, 4'h3, 32'h33, 1'b1);
        tbl[5]  = mk(1'b1, 3'b000, D0, DT0, 3'b000, 4'h1, 32'h11, 1'b1);
        tbl[6]  = mk(1'b1, 3'b010, 12'h3A1, {32'h33, 32'hDEADBEEF, 32'h11},
                     3'b010, 4'h1, 32'h11, 1'b0);
        tbl[7]  = mk(1'b1, 3'b000, D0, DT0, 3'b000, 4'hA, 32'hDEADBEEF, 1'b1);
        tbl[8]  = mk(1'b1, 3'b000, D0, DT0, 3'b000, 4'hA, 32'hDEADBEEF, 1'b0);
        tbl[9]  = mk(1'b1, 3'b101, D0, DT0, 3'b100, 4'hA, 32'hDEADBEEF, 1'b0);
        tbl[10] = mk(1'b0, 3'b111, D0, DT0, 3'b000, 4'h3, 32'h33, 1'b1);
        tbl[11] = mk(1'b1, 3'b111, D0, DT0, 3'b001, 4'h0, 32'h0, 1'b0);
        tbl[12] = mk(1'b1, 3'b111, D0, DT0, 3'b010, 4'h1, 32'h11, 1'b1);

        set_in(1'b0, 3'b000, D0, DT0, 1'b0, 4'h0, 4'h0, 4'h0);
        cyc();
        cyc();

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].rst, tbl[i].valid, tbl[i].dest, tbl[i].data, 1'b0, 4'h0, 4'h0, 4'h0);
            @(negedge clk);
            chk("tbl_ready",     32'(bus.Req_Ready),     32'(tbl[i].exp_ready));
            chk("tbl_write_en",  32'(bus.Write_En),      32'(tbl[i].exp_wr.en));
            chk("tbl_dest",      32'(bus.Destination),   32'(tbl[i].exp_wr.dest));
            chk("tbl_ldr_mux",   bus.LDR_MUX,            tbl[i].exp_wr.data);
            chk("tbl_busy",      32'(bus.Busy),          32'd0);
            chk("tbl_stall",     32'(bus.Stall),         32'd0);
            chk("tbl_rsv_ready", 32'(bus.Reserve_Ready), SB ? 32'(tbl[i].rst) : 32'd1);
            cyc();
        end

`ifdef REGBANK_ARB_SCOREBOARD_EN
        // Reserve r5, see the RAW stall, retire it with an ALU write.
        set_in(1'b1, 3'b000, D0, DT0, 1'b1, 4'h5, 4'h0, 4'h0);
        @(negedge clk);
        chk("r5_rsv_ready0", 32'(bus.Reserve_Ready), 32'd1);
        chk("r5_stall0",     32'(bus.Stall),         32'd0);
        cyc();
        set_in(1'b1, 3'b000, D0, DT0, 1'b1, 4'h5, 4'h5, 4'h0);
        @(negedge clk);
        chk("r5_busy",       32'(bus.Busy[5]),       32'd1);
        chk("r5_stall",      32'(bus.Stall),         32'd1);
        chk("r5_rsv_ready",  32'(bus.Reserve_Ready), 32'd0);
        cyc();
        set_in(1'b1, 3'b001, 12'h005, DT0, 1'b0, 4'h0, 4'h5, 4'h0);
        @(negedge clk);
        chk("r5_wr_ready",   32'(bus.Req_Ready),     32'b001);
        chk("r5_wr_stall",   32'(bus.Stall),         32'd1);
        cyc();
        set_in(1'b1, 3'b000, D0, DT0, 1'b0, 4'h0, 4'h5, 4'h0);
        @(negedge clk);
        chk("r5_done_en",    32'(bus.Write_En),      32'd1);
        chk("r5_done_dest",  32'(bus.Destination),   32'd5);
        chk("r5_done_busy",  32'(bus.Busy[5]),       32'd0);
        chk("r5_done_stall", 32'(bus.Stall),         32'd0);
        cyc();

        // Reserve r3 again in the cycle its LDR write retires: stays busy.
        set_in(1'b1, 3'b000, D0, DT0, 1'b1, 4'h3, 4'h0, 4'h0);
        cyc();
        set_in(1'b1, 3'b010, 12'h030, DT0, 1'b1, 4'h3, 4'h0, 4'h0);
        @(negedge clk);
        chk("r3_busy_pre",   32'(bus.Busy[3]),       32'd1);
        chk("r3_rsv_ready",  32'(bus.Reserve_Ready), 32'd1);
        chk("r3_ready",      32'(bus.Req_Ready),     32'b010);
        cyc();
        set_in(1'b1, 3'b000, D0, DT0, 1'b0, 4'h0, 4'h3, 4'h0);
        @(negedge clk);
        chk("r3_en",         32'(bus.Write_En),      32'd1);
        chk("r3_dest",       32'(bus.Destination),   32'd3);
        chk("r3_busy_post",  32'(bus.Busy[3]),       32'd1);
        chk("r3_stall",      32'(bus.Stall),         32'd1);
        cyc();
        set_in(1'b1, 3'b100, 12'h300, DT0, 1'b0, 4'h0, 4'h3, 4'h0);
        cyc();
        set_in(1'b1, 3'b000, D0, DT0, 1'b0, 4'h0, 4'h3, 4'h0);
        @(negedge clk);
        chk("r3_cleared",    32'(bus.Busy[3]),       32'd0);
        cyc();
`else
        // Without the scoreboard nothing ever stalls and reservations are free.
        for (int s = 0; s < 16; s++) begin
            set_in(1'b1, 3'b000, D0, DT0, 1'b1, 4'(s), 4'(s), 4'(15 - s));
            @(negedge clk);
            chk("nosb_stall",     32'(bus.Stall),         32'd0);
            chk("nosb_rsv_ready", 32'(bus.Reserve_Ready), 32'd1);
            cyc();
        end
`endif

        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)), 12'($urandom()),
                   {$urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            @(negedge clk);
            chk_model();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of write-back requesters (0 = ALU, 1 = LDR load, 2 = MOV/immediate).
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: Clock input 1, rising-edge clock; Reset_n input 1, synchronous active-low reset.
REQ-005 Req_Valid input NUM_REQ: per-requester write request.
REQ-006 Req_Dest input NUM_REQ*ADDR_W: packed destination per requester; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 Req_Data input NUM_REQ*DATA_W: packed write data per requester.
REQ-008 Req_Ready output NUM_REQ: one-hot grant; a request is accepted when Req_Valid[i] and Req_Ready[i] are both high.
REQ-009 Reserve_Valid input 1, Reserve_Dest input ADDR_W, Reserve_Ready output 1: issue-stage destination reservation.
REQ-010 Source1_ADDR and Source2_ADDR inputs ADDR_W: the issue stage's read addresses, used for hazard check.
REQ-011 Stall output 1: read-after-write hazard on a pending register.
REQ-012 Destination output ADDR_W, Write_En output 1, LDR_MUX output DATA_W: registered write port to the register bank.
REQ-013 Busy output 16: scoreboard of pending destinations.

Function
REQ-014 Arbitration SHALL be round-robin. Priority starts at requester (Ptr+1) mod NUM_REQ and searches upward with wrap-around.
REQ-015 At most one Req_Ready bit SHALL be high per cycle; Req_Ready SHALL be combinational from Req_Valid and Ptr.
REQ-016 On an accepted request from requester g, Ptr SHALL become g on the next edge. With no acceptance, Ptr SHALL hold.
REQ-017 Write latency SHALL be 1 cycle: the edge after acceptance drives Write_En=1, Destination=Req_Dest[g] and LDR_MUX=Req_Data[g] for exactly one cycle.
REQ-018 With no acceptance, Write_En SHALL be 0 the next cycle, and Destination/LDR_MUX SHALL hold their last values.
REQ-019 A requester holding Req_Valid without grant SHALL keep Dest/Data stable. No requester SHALL wait more than NUM_REQ-1 grants.
REQ-020 Scoreboard: an accepted reservation (Reserve_Valid and Reserve_Ready) SHALL set Busy[Reserve_Dest] on the next edge.
REQ-021 An accepted write SHALL clear Busy[Req_Dest[g]] on the next edge.
REQ-022 Reserve_Ready SHALL be 0 when Busy[Reserve_Dest]=1 (no double reservation, WAW blocked) and 1 otherwise.
REQ-023 If a reserve and a write target the same address in one cycle, the reserve SHALL win and Busy stays 1; the clear applies to the older entry.
REQ-024 A write to a register that is not busy SHALL be legal and SHALL leave Busy at 0.
REQ-025 Stall SHALL equal Busy[Source1_ADDR] OR Busy[Source2_ADDR], combinationally.
REQ-026 A write accepted in cycle N SHALL drop Stall from cycle N+1, aligned with Write_En.

Reset
REQ-027 While Reset_n=0 at a clock edge, the block SHALL set Ptr=NUM_REQ-1 (so requester 0 has first priority), Busy=0, Write_En=0, Destination=0 and LDR_MUX=0.
REQ-028 During reset, Req_Ready SHALL be 0 and Reserve_Ready SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight write: Write_En is 0 on the following cycle.

Configuration
REQ-030 Macro REGBANK_ARB_SCOREBOARD_EN: when defined, REQ-020 to REQ-026 apply.
REQ-031 When REGBANK_ARB_SCOREBOARD_EN is undefined, the scoreboard SHALL be removed: Busy=0, Stall=0, Reserve_Ready=1 constantly, and arbitration is unchanged.

Structure
REQ-032 A shared package SHALL hold REG_ADDR_W=4, REG_DATA_W=32, NUM_REGS=16, the requester index constants (REQ_ALU, REQ_LDR, REQ_MOV) and a packed write-port struct type (dest, data, en).
REQ-033 One sub-module, rr_arbiter (request vector plus pointer in, one-hot grant out), SHALL be instantiated. The scoreboard SHALL stay inline.

Verification
REQ-034 Reset release with all Req_Valid=3'b111 -> grants over three cycles are 001, 010, 100, then 001 again; Write_En is high on each following cycle.
REQ-035 Req_Valid=3'b010, Req_Dest[1]=4'hA, Req_Data[1]=32'hDEADBEEF -> the next cycle has Write_En=1, Destination=4'hA, LDR_MUX=32'hDEADBEEF; the cycle after has Write_En=0.
REQ-036 Reserve r5, then Source1_ADDR=5 -> Stall=1 and Reserve_Ready=0 for r5. ALU writes r5 -> Busy[5]=0 and Stall=0 on the cycle Write_En=1.
REQ-037 Same cycle: reserve r3 and an LDR write to r3 while Busy[3]=1 -> Busy[3] remains 1.
REQ-038 Reset_n=0 for one cycle while three requests are pending -> the next cycle has Write_En=0 and Busy=0, and requester 0 is granted first afterwards.
REQ-039 Build without REGBANK_ARB_SCOREBOARD_EN -> Stall=0 for any Source1_ADDR/Source2_ADDR, and Reserve_Ready=1 constantly.
